// File: rtl/svarog_pkg.sv
// svarog_pkg: shared types and constants for the svarog host interface
package svarog_pkg;
   typedef enum logic [2:0] {SZ_1B = 3'd0, SZ_2B = 3'd1, SZ_4B = 3'd2, SZ_8B = 3'd3} size_e;
   typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, RUN = 2'd2} state_e;
   localparam logic [7:0] OFF_CTRL       = 8'h00;
   localparam logic [7:0] OFF_START_ADDR = 8'h04;
   localparam logic [7:0] OFF_STATUS     = 8'h08;
   localparam int ST_BUSY     = 0;
   localparam int ST_DONE     = 1;
   localparam int ST_ERR_BUSY = 2;
   localparam int ST_ERR_TMO  = 3;
   localparam int ST_ERR_SIZE = 4;
   localparam int ST_IRQ_EN   = 5;
   // 8-byte accesses only exist on a 64-bit bus; codes above 3 are never legal
   function automatic logic size_ok(input size_e s, input int data_size);
      return (s == SZ_8B) ? (data_size == 64) : (s < SZ_8B);
   endfunction
endpackage

// File: rtl/svarog_rng_wdog.sv
// svarog_rng_wdog: counts consecutive RUN cycles spent waiting on the TRNG and flags a timeout.
// Ports: clk, areset (sync, active-high); i_run (FSM in RUN); i_req/i_ready (RNG handshake);
// o_tmo (combinational timeout, high in the cycle the count sits at TMO_CYCLES-1 with the wait still pending).
module svarog_rng_wdog #(
   parameter int TMO_CYCLES = 4096
)(
   input  logic clk,
   input  logic areset,
   input  logic i_run,
   input  logic i_req,
   input  logic i_ready,
   output logic o_tmo
);
   localparam int W = $clog2(TMO_CYCLES + 1);
   logic [W-1:0] r_cnt;
   logic w_pend;
   assign w_pend = i_run & i_req & ~i_ready;
   assign o_tmo = w_pend & (r_cnt == W'(TMO_CYCLES - 1));
   always_ff @(posedge clk) begin
      if (areset) r_cnt <= '0;
      else r_cnt <= w_pend ? r_cnt + 1'b1 : '0;
   end
endmodule

// File: rtl/svarog_host_if.sv
// svarog_host_if: host bus slave for the svarog engine -- control/status registers,
// operand and result banks, start/done/abort sequencing and a level interrupt.
// Ports: clk, areset (sync, active-high); a_i/c_i/w_i/s_i/d_i/d_o host bus (d_o registered);
// opd_o operand banks out; res_i engine results in; start_addr_o, eng_start_o, eng_abort_o,
// eng_done_i engine handshake; rand_req_i/rand_ready_i RNG wait; irq_o interrupt; ready_o in IDLE.
// Build option: SVAROG_RNG_TIMEOUT_EN adds the RNG wait watchdog and the abort path.
module svarog_host_if
   import svarog_pkg::*;
#(
   parameter int DATA_SIZE  = 32,
   parameter int ADDR_SIZE  = 32,
   parameter int BLOCK_SIZE = 256,
   parameter int NUM_OPD    = 6,
   parameter int NUM_RES    = 8,
   parameter int TMO_CYCLES = 4096
)(
   input  logic                          clk,
   input  logic                          areset,
   input  logic [ADDR_SIZE-1:0]          a_i,
   input  logic                          c_i,
   input  logic                          w_i,
   input  logic [2:0]                    s_i,
   input  logic [DATA_SIZE-1:0]          d_i,
   output logic [DATA_SIZE-1:0]          d_o,
   output logic [NUM_OPD*BLOCK_SIZE-1:0] opd_o,
   input  logic [NUM_RES*BLOCK_SIZE-1:0] res_i,
   output logic [7:0]                    start_addr_o,
   output logic                          eng_start_o,
   output logic                          eng_abort_o,
   input  logic                          eng_done_i,
   input  logic                          rand_req_i,
   input  logic                          rand_ready_i,
   output logic                          irq_o,
   output logic                          ready_o
);
   localparam int NB = BLOCK_SIZE / 8;
   localparam int DB = DATA_SIZE / 8;
   localparam int BW = ADDR_SIZE - 8;
   state_e r_state;
   logic [NUM_OPD*BLOCK_SIZE-1:0] r_opd;
   logic [NUM_RES*BLOCK_SIZE-1:0] r_res;
   logic [7:0] r_start_addr;
   logic [DATA_SIZE-1:0] r_d;
   logic r_done, r_err_busy, r_err_tmo, r_err_size, r_irq_en, r_irq, r_eng_start, r_eng_abort;
   logic [BW-1:0] w_bank;
   logic [7:0] w_off;
   size_e w_size;
   int w_n;
   logic w_size_ok, w_wr, w_idle, w_b0, w_ctrl_wr, w_sa_wr, w_st_wr, w_start_req, w_opd_wr;
   logic w_busy_err, w_done_ev, w_tmo_ev, w_tmo;
   logic [5:0] w_status;
   logic [63:0] w_reg64;
   logic [DATA_SIZE-1:0] w_rd_data;
   // byte lane j of an access lands on this byte of the addressed block (wraps at the block end)
   function automatic int bidx(input logic [7:0] off, input int j, input int n);
      return (int'(off) + (j & (n - 1))) % NB;
   endfunction
   assign w_bank = a_i[ADDR_SIZE-1:8];
   assign w_off = a_i[7:0];
   assign w_size = size_e'(s_i);
   assign w_n = 1 << s_i[1:0];
   assign w_size_ok = size_ok(w_size, DATA_SIZE);
   assign w_wr = c_i & w_i & w_size_ok;
   assign w_idle = (r_state == IDLE);
   assign w_b0 = (w_bank == '0);
   assign w_ctrl_wr = w_wr & w_b0 & (w_off == OFF_CTRL);
   assign w_sa_wr = w_wr & w_b0 & (w_off == OFF_START_ADDR);
   assign w_st_wr = w_wr & w_b0 & (w_off == OFF_STATUS);
   assign w_start_req = w_ctrl_wr & d_i[0];
   assign w_opd_wr = w_wr & (w_bank >= BW'(1)) & (w_bank <= BW'(NUM_OPD));
   assign w_busy_err = ~w_idle & (w_opd_wr | w_sa_wr | w_start_req);
   assign w_done_ev = (r_state == RUN) & eng_done_i;
   assign w_tmo_ev = (r_state == RUN) & w_tmo & ~eng_done_i;
`ifdef SVAROG_RNG_TIMEOUT_EN
   svarog_rng_wdog #(.TMO_CYCLES(TMO_CYCLES)) u_wdog (
      .clk     (clk),
      .areset  (areset),
      .i_run   (r_state == RUN),
      .i_req   (rand_req_i),
      .i_ready (rand_ready_i),
      .o_tmo   (w_tmo)
   );
`else
   logic w_unused;
   assign w_unused = &{1'b0, rand_req_i, rand_ready_i, TMO_CYCLES != 0};
   assign w_tmo = 1'b0;
`endif
   always_comb begin
      w_status = '0;
      w_status[ST_BUSY] = ~w_idle;
      w_status[ST_DONE] = r_done;
      w_status[ST_ERR_BUSY] = r_err_busy;
      w_status[ST_ERR_TMO] = r_err_tmo;
      w_status[ST_ERR_SIZE] = r_err_size;
      w_status[ST_IRQ_EN] = r_irq_en;
      w_reg64 = (w_off == OFF_START_ADDR) ? {56'b0, r_start_addr} :
                (w_off == OFF_STATUS) ? {58'b0, w_status} : '0;
   end
   // each output lane repeats the n-byte value, giving the replicated read word
   always_comb begin
      w_rd_data = '0;
      for (int j = 0; j < DB; j++) begin
         if (w_b0) w_rd_data[j*8 +: 8] = w_reg64[(j & (w_n - 1))*8 +: 8];
         for (int k = 0; k < NUM_OPD; k++)
            if (w_bank == BW'(k + 1)) w_rd_data[j*8 +: 8] = r_opd[k*BLOCK_SIZE + bidx(w_off, j, w_n)*8 +: 8];
         for (int k = 0; k < NUM_RES; k++)
            if (w_bank == BW'(NUM_OPD + k + 1)) w_rd_data[j*8 +: 8] = r_res[k*BLOCK_SIZE + bidx(w_off, j, w_n)*8 +: 8];
      end
   end
   always_ff @(posedge clk) begin
      if (areset) begin
         r_state <= IDLE;
         r_opd <= '0;
         r_res <= '0;
         r_start_addr <= '0;
         r_d <= '0;
         r_done <= 1'b0;
         r_err_busy <= 1'b0;
         r_err_tmo <= 1'b0;
         r_err_size <= 1'b0;
         r_irq_en <= 1'b0;
         r_irq <= 1'b0;
         r_eng_start <= 1'b0;
         r_eng_abort <= 1'b0;
      end else begin
         r_eng_start <= 1'b0;
         r_eng_abort <= 1'b0;
         if (c_i & ~w_i) r_d <= w_size_ok ? w_rd_data : '0;
         if (c_i & ~w_size_ok) r_err_size <= 1'b1;
         if (w_busy_err) r_err_busy <= 1'b1;
         if (w_ctrl_wr) r_irq_en <= d_i[1];
         if (w_sa_wr & w_idle) r_start_addr <= d_i[7:0];
         if (w_opd_wr & w_idle)
            for (int k = 0; k < NUM_OPD; k++)
               if (w_bank == BW'(k + 1))
                  for (int j = 0; j < DB; j++)
                     if (j < w_n) r_opd[k*BLOCK_SIZE + bidx(w_off, j, w_n)*8 +: 8] <= d_i[j*8 +: 8];
         if (w_st_wr) begin
            if (d_i[ST_DONE]) r_done <= 1'b0;
            if (d_i[ST_ERR_BUSY]) r_err_busy <= 1'b0;
            if (d_i[ST_ERR_TMO]) r_err_tmo <= 1'b0;
            if (d_i[ST_ERR_SIZE]) r_err_size <= 1'b0;
         end
         // clears first so a same-cycle set event wins
         if ((w_ctrl_wr & d_i[2]) | (w_st_wr & (d_i[ST_DONE] | d_i[ST_ERR_TMO]))) r_irq <= 1'b0;
         if ((w_done_ev | w_tmo_ev) & r_irq_en) r_irq <= 1'b1;
         case (r_state)
            IDLE: if (w_start_req) begin
               r_state <= START;
               r_eng_start <= 1'b1;
            end
            START: r_state <= RUN;
            RUN: if (eng_done_i) begin
               r_state <= IDLE;
               r_res <= res_i;
               r_done <= 1'b1;
            end else if (w_tmo) begin
               r_state <= IDLE;
               r_eng_abort <= 1'b1;
               r_err_tmo <= 1'b1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   assign d_o = r_d;
   assign opd_o = r_opd;
   assign start_addr_o = r_start_addr;
   assign eng_start_o = r_eng_start;
`ifdef SVAROG_RNG_TIMEOUT_EN
   assign eng_abort_o = r_eng_abort;
`else
   assign eng_abort_o = 1'b0;
   logic w_unused_abort;
   assign w_unused_abort = r_eng_abort;
`endif
   assign irq_o = r_irq;
   assign ready_o = w_idle;
endmodule

// File: tb/tb_svarog_host_if.sv
// tb_svarog_host_if: directed + randomized self-checking bench for svarog_host_if
module tb_svarog_host_if;
   localparam int DS = 32, AS = 32, BS = 256, NO = 6, NR = 8, TMO = 16, NB = BS / 8;
   logic clk = 1'b0;
   logic areset, c_i, w_i, eng_done_i, rand_req_i, rand_ready_i;
   logic [AS-1:0] a_i;
   logic [2:0] s_i;
   logic [DS-1:0] d_i, d_o;
   logic [NO*BS-1:0] opd_o;
   logic [NR*BS-1:0] res_i;
   logic [7:0] start_addr_o;
   logic eng_start_o, eng_abort_o, irq_o, ready_o;
   int n_tests = 0, n_fail = 0, n_start = 0, n_abort = 0;
   logic [7:0] mopd[NO][NB];
   logic [7:0] mres[NR][NB];

   svarog_host_if #(.DATA_SIZE(DS), .ADDR_SIZE(AS), .BLOCK_SIZE(BS), .NUM_OPD(NO), .NUM_RES(NR), .TMO_CYCLES(TMO)) dut (
      .clk(clk), .areset(areset), .a_i(a_i), .c_i(c_i), .w_i(w_i), .s_i(s_i), .d_i(d_i), .d_o(d_o),
      .opd_o(opd_o), .res_i(res_i), .start_addr_o(start_addr_o), .eng_start_o(eng_start_o),
      .eng_abort_o(eng_abort_o), .eng_done_i(eng_done_i), .rand_req_i(rand_req_i),
      .rand_ready_i(rand_ready_i), .irq_o(irq_o), .ready_o(ready_o));

   always #5 clk = ~clk;
   always @(negedge clk) begin
      if (eng_start_o) n_start++;
      if (eng_abort_o) n_abort++;
   end
   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [BS-1:0] obs, input logic [BS-1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic acc(input logic w, input int bank, input int off, input int s, input logic [31:0] d);
      @(negedge clk);
      c_i = 1'b1; w_i = w; a_i = AS'(bank * 256 + off); s_i = 3'(s); d_i = d;
      @(negedge clk);
      c_i = 1'b0; w_i = 1'b0;
   endtask

   task automatic mwr(input int bank, input int off, input int s, input logic [31:0] d);
      for (int i = 0; i < (1 << s); i++) mopd[bank-1][(off + i) % NB] = d[8*i +: 8];
   endtask

   function automatic logic [31:0] mrd(input int bank, input int off, input int s);
      int n;
      logic [31:0] v;
      n = 1 << s;
      v = '0;
      for (int i = 0; i < n; i++)
         v[8*i +: 8] = (bank >= 1 && bank <= NO) ? mopd[bank-1][(off + i) % NB] :
                       (bank > NO && bank <= NO + NR) ? mres[bank-NO-1][(off + i) % NB] : 8'h00;
      return (n == 1) ? {4{v[7:0]}} : (n == 2) ? {2{v[15:0]}} : v;
   endfunction

   function automatic logic [BS-1:0] mbank(input int k);
      logic [BS-1:0] r;
      for (int i = 0; i < NB; i++) r[8*i +: 8] = mopd[k][i];
      return r;
   endfunction

   task automatic capture_model();
      for (int k = 0; k < NR; k++)
         for (int i = 0; i < NB; i++) mres[k][i] = res_i[k*BS + 8*i +: 8];
   endtask

   task automatic rand_res();
      for (int i = 0; i < NR * BS / 32; i++) res_i[32*i +: 32] = $urandom();
   endtask

   initial begin
      int bank, off, s, snap, cyc;
      logic [31:0] d;
      areset = 1'b1; c_i = 1'b0; w_i = 1'b0; a_i = '0; s_i = '0; d_i = '0; res_i = '0;
      eng_done_i = 1'b0; rand_req_i = 1'b0; rand_ready_i = 1'b0;
      for (int k = 0; k < NO; k++) for (int i = 0; i < NB; i++) mopd[k][i] = 8'h00;
      for (int k = 0; k < NR; k++) for (int i = 0; i < NB; i++) mres[k][i] = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_d_o", d_o, 0);
      chk("rst_opd", opd_o[BS-1:0], 0);
      chk("rst_start_addr", start_addr_o, 0);
      chk("rst_outs", {eng_start_o, eng_abort_o, irq_o, ready_o}, 4'b0001);
      areset = 1'b0;
      acc(0, 0, 8'h08, 2, 0);
      chk("rst_status", d_o, 0);

      // wrapping 4-byte write at the end of operand bank 0
      acc(1, 1, 8'h1E, 2, 32'hDDCCBBAA);
      mwr(1, 8'h1E, 2, 32'hDDCCBBAA);
      chk("wrap_bytes", {opd_o[8*1 +: 8], opd_o[8*0 +: 8], opd_o[8*31 +: 8], opd_o[8*30 +: 8]}, 32'hDDCCBBAA);
      chk("wrap_bank", opd_o[BS-1:0], mbank(0));

      // random accesses over operand, result and unmapped banks
      for (int it = 0; it < 48; it++) begin
         bank = $urandom_range(1, 15); off = $urandom_range(0, 255); s = $urandom_range(0, 2); d = $urandom();
         if ($urandom_range(0, 1) == 1) begin
            acc(1, bank, off, s, d);
            if (bank <= NO) mwr(bank, off, s, d);
         end else begin
            acc(0, bank, off, s, d);
            chk($sformatf("rand_rd b%0d o%0d s%0d", bank, off, s), d_o, mrd(bank, off, s));
         end
      end
      for (int k = 0; k < NO; k++) chk($sformatf("rand_opd%0d", k), opd_o[k*BS +: BS], mbank(k));

      acc(1, 0, 8'h04, 0, 32'h0000003C);
      chk("start_addr_o", start_addr_o, 8'h3C);
      acc(0, 0, 8'h04, 0, 0);
      chk("start_addr_rd", d_o, 32'h3C3C3C3C);

      // run A: no irq, busy operand write, done captures results
      rand_res();
      acc(1, 0, 8'h00, 2, 32'h1);
      repeat (2) @(negedge clk);
      acc(1, 1, 0, 2, 32'h11223344);
      chk("busy_opd_unchanged", opd_o[BS-1:0], mbank(0));
      acc(0, 0, 8'h08, 2, 0);
      chk("busy_status", d_o, 32'h05);
      acc(0, NO + 1, 0, 2, 0);
      chk("res_before_capture", d_o, 0);
      acc(1, 0, 8'h04, 0, 32'h77);
      chk("busy_start_addr", start_addr_o, 8'h3C);
      eng_done_i = 1'b1;
      @(negedge clk);
      eng_done_i = 1'b0;
      capture_model();
      chk("runA_irq_off", {irq_o, ready_o}, 2'b01);
      acc(0, 0, 8'h08, 2, 0);
      chk("runA_status", d_o, 32'h06);
      acc(1, 0, 8'h08, 2, 32'h1E);

      // run B: irq enabled, done after 10 cycles with byte 0x5A
      snap = n_start;
      rand_res();
      res_i[7:0] = 8'h5A;
      acc(1, 0, 8'h00, 2, 32'h3);
      acc(0, NO + 1, 0, 0, 0);
      chk("res_prev_during_run", d_o, mrd(NO + 1, 0, 0));
      repeat (8) @(negedge clk);
      chk("run_not_ready", ready_o, 1'b0);
      eng_done_i = 1'b1;
      @(negedge clk);
      eng_done_i = 1'b0;
      capture_model();
      chk("irq_after_done", irq_o, 1'b1);
      chk("start_pulses", n_start - snap, 1);
      acc(0, NO + 1, 0, 0, 0);
      chk("res_5a", d_o, 32'h5A5A5A5A);
      acc(0, 0, 8'h08, 2, 0);
      chk("runB_status", d_o, 32'h22);
      acc(1, 0, 8'h00, 2, 32'h6);
      chk("irq_ctrl_clear", irq_o, 1'b0);
      acc(1, 0, 8'h08, 2, 32'h1E);
      acc(1, 0, 8'h00, 2, 32'h0);

      for (int it = 0; it < 16; it++) begin
         bank = $urandom_range(NO + 1, NO + NR); off = $urandom_range(0, 255); s = $urandom_range(0, 2);
         acc(0, bank, off, s, 0);
         chk($sformatf("res_rd b%0d o%0d s%0d", bank, off, s), d_o, mrd(bank, off, s));
      end

      // done while idle must be ignored
      rand_res();
      eng_done_i = 1'b1;
      @(negedge clk);
      eng_done_i = 1'b0;
      acc(0, NO + 2, 4, 2, 0);
      chk("idle_done_res", d_o, mrd(NO + 2, 4, 2));
      acc(0, 0, 8'h08, 2, 0);
      chk("idle_done_status", d_o, 0);

      // RNG wait: timeout (macro on) or no abort (macro off)
      snap = n_abort;
      rand_req_i = 1'b1;
      acc(1, 0, 8'h00, 2, 32'h1);
`ifdef SVAROG_RNG_TIMEOUT_EN
      cyc = 0;
      while (!eng_abort_o && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      chk("tmo_cycles", cyc, 17);
      repeat (2) @(negedge clk);
      chk("abort_pulses", n_abort - snap, 1);
      acc(0, 0, 8'h08, 2, 0);
      chk("tmo_status", d_o, 32'h08);
      acc(1, 0, 8'h08, 2, 32'h1E);
      snap = n_abort;
      acc(1, 0, 8'h00, 2, 32'h1);
      repeat (16) @(negedge clk);
      eng_done_i = 1'b1;
      @(negedge clk);
      eng_done_i = 1'b0;
      repeat (2) @(negedge clk);
      chk("coinc_no_abort", n_abort - snap, 0);
      acc(0, 0, 8'h08, 2, 0);
      chk("coinc_status", d_o, 32'h02);
`else
      repeat (40) @(negedge clk);
      chk("notmo_still_run", ready_o, 1'b0);
      chk("notmo_no_abort", n_abort - snap, 0);
      eng_done_i = 1'b1;
      @(negedge clk);
      eng_done_i = 1'b0;
      acc(0, 0, 8'h08, 2, 0);
      chk("notmo_status", d_o, 32'h02);
`endif
      rand_req_i = 1'b0;
      acc(1, 0, 8'h08, 2, 32'h1E);

      // illegal size codes
      acc(0, 1, 0, 2, 0);
      chk("pre_size_rd", d_o, mrd(1, 0, 2));
      acc(1, 1, 0, 3, 32'hFFFFFFFF);
      chk("size3_no_write", opd_o[BS-1:0], mbank(0));
      acc(0, 0, 8'h08, 2, 0);
      chk("size3_status", d_o, 32'h10);
      acc(0, 1, 0, 3, 0);
      chk("size3_rd_zero", d_o, 0);
      acc(0, 1, 0, 2, 0);
      acc(0, 1, 0, 6, 0);
      chk("size6_rd_zero", d_o, 0);
      acc(1, 0, 8'h08, 2, 32'h1E);

      // reset during RUN: back to IDLE, no abort, everything cleared
      snap = n_abort;
      acc(1, 0, 8'h00, 2, 32'h3);
      repeat (3) @(negedge clk);
      areset = 1'b1;
      @(negedge clk);
      areset = 1'b0;
      chk("rstrun_ready", ready_o, 1'b1);
      chk("rstrun_regs", {start_addr_o, d_o, irq_o}, 0);
      for (int k = 0; k < NO; k++) chk($sformatf("rstrun_opd%0d", k), opd_o[k*BS +: BS], 0);
      repeat (2) @(negedge clk);
      chk("rstrun_no_abort", n_abort - snap, 0);
      acc(0, NO + 1, 0, 2, 0);
      chk("rstrun_res", d_o, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/svarog_host_if.md
SVAROG_HOST_IF -- requirements
Module: svarog_host_if

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 32, meaning bus data width; legal values 32 or 64.
REQ-002 SHALL have parameter ADDR_SIZE, default 32, meaning bus address width.
REQ-003 SHALL have parameter BLOCK_SIZE, default 256, meaning operand/result width in bits; must be a multiple of 64 and at most 2048.
REQ-004 SHALL have parameter NUM_OPD, default 6, meaning number of host-writable operand banks.
REQ-005 SHALL have parameter NUM_RES, default 8, meaning number of host-readable result banks.
REQ-006 SHALL have parameter TMO_CYCLES, default 4096, meaning the random-number wait limit.
REQ-007 SHALL have the following ports:
- clk  in  1  single clock; all logic on its rising edge.
- areset  in  1  reset, synchronous, active-high.
- a_i  in  ADDR_SIZE  bus address.
- c_i  in  1  bus cycle select.
- w_i  in  1  write when high, read when low.
- s_i  in  3  access size code: 0=1B, 1=2B, 2=4B, 3=8B.
- d_i  in  DATA_SIZE  write data.
- d_o  out  DATA_SIZE  read data, registered.
- opd_o  out  NUM_OPD*BLOCK_SIZE  flattened operand banks; bank k occupies bits [k*BLOCK_SIZE +: BLOCK_SIZE].
- res_i  in  NUM_RES*BLOCK_SIZE  engine results, same flattening.
- start_addr_o  out  8  microcode start address.
- eng_start_o  out  1  engine start pulse.
- eng_abort_o  out  1  engine abort pulse.
- eng_done_i  in  1  engine completion pulse.
- rand_req_i  in  1  engine level request for a random number.
- rand_ready_i  in  1  TRNG ready.
- irq_o  out  1  level interrupt.
- ready_o  out  1  high when the FSM is in IDLE.

Function
REQ-008 SHALL decode bank = a_i[ADDR_SIZE-1:8] and byte offset = a_i[7:0].
REQ-009 Bank 0 register map SHALL be:
- 0x00 CTRL (write only): bit0 start, bit1 irq_en (stored), bit2 irq clear.
- 0x04 START_ADDR (read/write, 8 bits).
- 0x08 STATUS: bit0 busy, bit1 done, bit2 err_busy, bit3 err_tmo, bit4 err_size, bit5 irq_en. Writing 1 to bits 1-4 clears the corresponding flag.
REQ-010 Banks 1..NUM_OPD SHALL be byte-addressed operand registers. A write of n bytes updates bytes offset..offset+n-1, each byte index taken modulo BLOCK_SIZE/8, little-endian from d_i[7:0].
REQ-011 Banks NUM_OPD+1..NUM_OPD+NUM_RES SHALL be read-only result registers, byte-addressed with the same modulo wrap.
REQ-012 On a read, d_o SHALL update one cycle after c_i&~w_i; the n-byte value is replicated across DATA_SIZE. Unmapped addresses read 0, and d_o holds its value when no read is in progress.
REQ-013 s_i=3 with DATA_SIZE=32, or s_i>3, SHALL suppress the access and set err_size; a read of this kind returns 0.
REQ-014 The FSM SHALL have the states IDLE, START, RUN:
- IDLE->START on a CTRL write with bit0=1.
- START: eng_start_o=1 for exactly one cycle, then ->RUN.
- RUN->IDLE on eng_done_i: capture res_i into the result registers and set done.
- RUN->IDLE on timeout: eng_abort_o=1 for one cycle and set err_tmo.
REQ-015 eng_done_i and timeout in the same cycle SHALL be treated as done; no abort pulse is issued.
REQ-016 An operand write, START_ADDR write, or start request while not in IDLE SHALL be ignored and set err_busy. STATUS writes and reads of any bank remain allowed.
REQ-017 Result registers SHALL change only on capture, so reads during RUN return the previous result.
REQ-018 irq_o SHALL be set on the done or err_tmo event when irq_en=1, and cleared by CTRL bit2 or by a STATUS write clearing done/err_tmo. A set in the same cycle as a clear SHALL win.
REQ-019 eng_done_i while in IDLE or START SHALL be ignored.

Reset
REQ-020 While areset=1 at a clock edge, the following SHALL all be 0: every operand and result register, start_addr_o, all status flags, irq_en, d_o, eng_start_o, eng_abort_o and irq_o. The FSM goes to IDLE, so ready_o=1.
REQ-021 Reset asserted during RUN SHALL return the FSM to IDLE with no abort pulse.

Configuration
REQ-022 With SVAROG_RNG_TIMEOUT_EN defined, a counter SHALL increment each RUN cycle with rand_req_i&~rand_ready_i, clear otherwise, and signal timeout on reaching TMO_CYCLES-1.
REQ-023 Without SVAROG_RNG_TIMEOUT_EN, no counter SHALL be built, timeout is constant 0, eng_abort_o is tied to 0, and STATUS bit3 reads 0.

Structure
REQ-024 Package svarog_pkg SHALL hold the size-code enum, the FSM state enum, and the bank-0 offset and STATUS bit-position constants.
REQ-025 The timeout counter SHALL be sub-module svarog_rng_wdog, instantiated only under the macro.

Verification
REQ-026 Bench SHALL cover:
- Write 0xDDCCBBAA, s_i=2, bank1 offset 0x1E (BLOCK_SIZE=256) -> opd bank0 bytes 30,31,0,1 = AA,BB,CC,DD.
- Start, then eng_done_i after 10 cycles with res_i bank0 byte0=0x5A, irq_en=1 -> eng_start_o one pulse; irq_o=1 the cycle after done; 1-byte read of bank NUM_OPD+1 offset 0 -> d_o=0x5A5A5A5A.
- Operand write during RUN -> register unchanged; STATUS=0x05 (busy, err_busy).
- Macro on, TMO_CYCLES=16, rand_req_i held high, rand_ready_i low -> eng_abort_o pulses after 16 RUN cycles with the request pending; STATUS=0x08.
- eng_done_i coincident with timeout -> done=1, err_tmo=0, no abort.
- s_i=3 with DATA_SIZE=32 -> no write; err_size=1.
